vga_frame_scheduler: RTL and testbench
======================================

// Module: vga_frame_scheduler
// PURPOSE
//   Frame-synchronous update sequencer for the VGA snake renderer. On each screenEnd pulse it
//   rebuilds a tile-occupancy bitmap from the packed snake segment buses. It also converts the
//   score and high score to BCD for the digit-sprite path. Bitmap is double-buffered: the pixel
//   path reads a stable front buffer; the result publishes with a one-cycle buffer swap.
// PARAMETERS
//   MAX_SEGS      100  segment slots in x_values/y_values (32 bits each)
//   GRID_W        12   board width in tiles
//   GRID_H        10   board height in tiles
//   SCORE_DIGITS  3    BCD digits produced per score value
// PORTS
//   clk           in   1                 system clock; single clock domain
//   reset         in   1                 asynchronous, active-high
//   screen_end    in   1                 1-cycle pulse between frames (from timing generator)
//   x_values      in   32*MAX_SEGS       segment tile x; slot i = [32*i +: 32]; -1 = unused
//   y_values      in   32*MAX_SEGS       segment tile y; same packing
//   score         in   32                current score (unsigned)
//   high_score    in   32                high score (unsigned)
//   tile_x        in   $clog2(GRID_W)    pixel-path lookup column
//   tile_y        in   $clog2(GRID_H)    pixel-path lookup row
//   tile_occupied out  1                 front-buffer bit at (tile_x,tile_y); combinational; 0 if off-grid
//   score_bcd     out  4*SCORE_DIGITS    published score digits, digit 0 = ones in [3:0]
//   high_bcd      out  4*SCORE_DIGITS    published high-score digits
//   frame_ready   out  1                 1-cycle pulse on buffer swap
//   busy          out  1                 high in every state except IDLE
//   oob_seen      out  1                 last published frame skipped an off-grid segment
//   dropped_cnt   out  8                 screen_end pulses ignored while busy (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async): state=IDLE; both bitmaps=0; front_sel=0.
//     Reset values: score_bcd=0, high_bcd=0, frame_ready=0, busy=0, oob_seen=0, dropped_cnt=0.
//     Reset mid-frame aborts all work; nothing is published.
//   FSM:
//     IDLE -> CLEAR on screen_end. Latch score and high_score into snapshot registers.
//     CLEAR: clear one back-buffer row per cycle for GRID_H cycles, then go to SCAN.
//     SCAN: process slot i in cycle i, starting at i=0.
//       Terminator: slot x==32'hFFFFFFFF or y==32'hFFFFFFFF ends SCAN immediately; slot not written.
//       Valid slot: x<GRID_W and y<GRID_H (unsigned) sets back-buffer bit [y][x].
//       Other slots: skipped; set the back-buffer oob flag.
//       After slot MAX_SEGS-1 or a terminator, go to BCD.
//     BCD: double-dabble both snapshots in parallel, one shift per cycle, exactly 32 cycles.
//       Saturation: a snapshot >= 10**SCORE_DIGITS converts as all-9s (999 by default).
//     SWAP: 1 cycle. front_sel toggles. Update score_bcd, high_bcd and oob_seen.
//       Assert frame_ready. Go to IDLE.
//   Latency: screen_end sampled at cycle 0 -> frame_ready at cycle 1+GRID_H+k+32,
//     where k = slots scanned (terminator counts, k<=MAX_SEGS).
//     Default worst case: 1+10+100+32 = cycle 143.
//   Upstream requirement: x_values/y_values are held stable from screen_end to frame_ready.
//   Duplicate segments set the same bit; this is idempotent.
//   The old front buffer is overwritten only after it becomes the back buffer.
//   screen_end while busy is ignored; the frame in flight is unaffected.
//   screen_end in the SWAP cycle is also ignored; busy is still high then.
//   Outputs change only in SWAP. tile_occupied never shows a partial frame.
// CONFIGURATION
//   FRAME_STATS_EN defined:
//     dropped_cnt increments, saturating at 255, on every ignored screen_end.
//     It clears only on reset.
//   FRAME_STATS_EN undefined:
//     dropped_cnt is tied to 8'd0; no counter logic is synthesized.
// TESTING
//   1 Reset, then screen_end; slots 0..2 = (3,4),(4,4),(5,4); slot 3 = -1; score=7, high=42
//     -> frame_ready at cycle 1+10+4+32=47.
//     -> bits (3,4),(4,4),(5,4) =1, all others 0; score_bcd=12'h007; high_bcd=12'h042.
//   2 All 100 slots valid with (i%12, i/12 % 10)
//     -> frame_ready at cycle 143; 100 distinct bits set; oob_seen=0.
//   3 Slot 0=(12,0), slot 1=(0,10), slot 2=(2,2), slot 3=-1
//     -> only (2,2) set; oob_seen=1; the next clean frame clears oob_seen.
//   4 score=1000, high=32'hFFFFFFFF -> score_bcd=12'h999, high_bcd=12'h999.
//   5 Extra screen_end pulses at cycles 20 and 60 of a frame
//     -> one frame_ready only; tile_occupied holds the prior frame until SWAP.
//     -> dropped_cnt=2 with FRAME_STATS_EN, 0 without.
//   6 Assert reset at cycle 50 of a frame
//     -> no frame_ready; tile_occupied=0 everywhere; busy=0; all BCD outputs 0.

Source files
------------

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: frame-synchronous tile-bitmap rebuild and score BCD conversion, double-buffered.
// Optional FRAME_STATS_EN enables the saturating dropped screen_end counter.
module vga_frame_scheduler #(
  parameter int MAX_SEGS     = 100,
  parameter int GRID_W       = 12,
  parameter int GRID_H       = 10,
  parameter int SCORE_DIGITS = 3,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int BW = 4 * SCORE_DIGITS
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     screen_end_i,
  input  logic [32*MAX_SEGS-1:0]   x_values_i,
  input  logic [32*MAX_SEGS-1:0]   y_values_i,
  input  logic [31:0]              score_i,
  input  logic [31:0]              high_score_i,
  input  logic [XW-1:0]            tile_x_i,
  input  logic [YW-1:0]            tile_y_i,
  output logic                     tile_occupied_o,
  output logic [BW-1:0]            score_bcd_o,
  output logic [BW-1:0]            high_bcd_o,
  output logic                     frame_ready_o,
  output logic                     busy_o,
  output logic                     oob_seen_o,
  output logic [7:0]               dropped_cnt_o
);
  localparam int CW = $clog2(MAX_SEGS + GRID_H + 32);
  localparam int SW = $clog2(32 * MAX_SEGS);
  localparam logic [31:0] LIM = 32'(10 ** SCORE_DIGITS);
  localparam logic [31:0] SAT = LIM - 32'd1;
  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, BCD, SWAP} state_t;
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              front_q, oob_q, oob_seen_q, frame_ready_q;
  logic [GRID_W-1:0] bm_q [2][GRID_H];
  logic [BW+31:0]    sdd_q, hdd_q;
  logic [BW-1:0]     score_bcd_q, high_bcd_q;
  logic [SW-1:0]     slot_base;
  logic [31:0]       slot_x, slot_y;
  logic              slot_term, slot_valid;

  function automatic logic [31:0] sat(input logic [31:0] v);
    return v >= LIM ? SAT : v;
  endfunction

  // One double-dabble step: add 3 to every digit >= 5, then shift the whole register left.
  function automatic logic [BW+31:0] dab(input logic [BW+31:0] v);
    logic [BW+31:0] r;
    r = v;
    for (int d = 0; d < SCORE_DIGITS; d++)
      r[32+4*d +: 4] = r[32+4*d +: 4] >= 4'd5 ? r[32+4*d +: 4] + 4'd3 : r[32+4*d +: 4];
    return r << 1;
  endfunction

  always_comb begin
    slot_base  = SW'(cnt_q) << 5;
    slot_x     = x_values_i[slot_base +: 32];
    slot_y     = y_values_i[slot_base +: 32];
    slot_term  = &slot_x || &slot_y;
    slot_valid = slot_x < 32'(GRID_W) && slot_y < 32'(GRID_H);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      front_q       <= 1'b0;
      oob_q         <= 1'b0;
      oob_seen_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      sdd_q         <= '0;
      hdd_q         <= '0;
      score_bcd_q   <= '0;
      high_bcd_q    <= '0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < GRID_H; r++)
          bm_q[b][r] <= '0;
    end else begin
      frame_ready_q <= 1'b0;
      case (state_q)
        IDLE: if (screen_end_i) begin
          state_q <= CLEAR;
          cnt_q   <= '0;
          oob_q   <= 1'b0;
          sdd_q   <= {{BW{1'b0}}, sat(score_i)};
          hdd_q   <= {{BW{1'b0}}, sat(high_score_i)};
        end
        CLEAR: begin
          bm_q[~front_q][cnt_q[YW-1:0]] <= '0;
          cnt_q   <= cnt_q == CW'(GRID_H - 1) ? '0 : cnt_q + 1'b1;
          state_q <= cnt_q == CW'(GRID_H - 1) ? SCAN : CLEAR;
        end
        SCAN: begin
          if (!slot_term && slot_valid) bm_q[~front_q][slot_y[YW-1:0]][slot_x[XW-1:0]] <= 1'b1;
          if (!slot_term && !slot_valid) oob_q <= 1'b1;
          cnt_q   <= slot_term || cnt_q == CW'(MAX_SEGS - 1) ? '0 : cnt_q + 1'b1;
          state_q <= slot_term || cnt_q == CW'(MAX_SEGS - 1) ? BCD : SCAN;
        end
        BCD: begin
          sdd_q   <= dab(sdd_q);
          hdd_q   <= dab(hdd_q);
          cnt_q   <= cnt_q == CW'(31) ? '0 : cnt_q + 1'b1;
          state_q <= cnt_q == CW'(31) ? SWAP : BCD;
        end
        SWAP: begin
          front_q       <= ~front_q;
          score_bcd_q   <= sdd_q[BW+31:32];
          high_bcd_q    <= hdd_q[BW+31:32];
          oob_seen_q    <= oob_q;
          frame_ready_q <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FRAME_STATS_EN
  logic [7:0] drop_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) drop_q <= '0;
    else if (screen_end_i && state_q != IDLE && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end
  assign dropped_cnt_o = drop_q;
`else
  assign dropped_cnt_o = 8'd0;
`endif

  assign tile_occupied_o = 32'(tile_x_i) < 32'(GRID_W) && 32'(tile_y_i) < 32'(GRID_H) &&
                           bm_q[front_q][tile_y_i][tile_x_i];
  assign score_bcd_o   = score_bcd_q;
  assign high_bcd_o    = high_bcd_q;
  assign frame_ready_o = frame_ready_q;
  assign busy_o        = state_q != IDLE;
  assign oob_seen_o    = oob_seen_q;
endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb_vga_frame_scheduler: directed checks of latency, bitmap, BCD, drops and reset abort.
module tb_vga_frame_scheduler;
  localparam int MS = 100;
  logic clk = 1'b0, reset = 1'b1, screen_end = 1'b0;
  logic [32*MS-1:0] xv, yv;
  logic [31:0] score = '0, high = '0;
  logic [3:0] tx = '0, ty = '0;
  logic occ, fr, busy, oob;
  logic [11:0] sbcd, hbcd;
  logic [7:0] drop;
  int n_cmp = 0, n_bad = 0;
  logic expb [16][16];
  logic [7:0] exp_drop;

  vga_frame_scheduler dut (
    .clk_i(clk), .reset_i(reset), .screen_end_i(screen_end),
    .x_values_i(xv), .y_values_i(yv), .score_i(score), .high_score_i(high),
    .tile_x_i(tx), .tile_y_i(ty), .tile_occupied_o(occ),
    .score_bcd_o(sbcd), .high_bcd_o(hbcd), .frame_ready_o(fr),
    .busy_o(busy), .oob_seen_o(oob), .dropped_cnt_o(drop)
  );

  always #5 clk = ~clk;

  task automatic set_slot(input int i, input logic [31:0] x, input logic [31:0] y);
    xv[32*i +: 32] = x;
    yv[32*i +: 32] = y;
  endtask

  task automatic clear_all;
    xv = '1;
    yv = '1;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        expb[y][x] = 1'b0;
  endtask

  task automatic count_bad(output int bad);
    bad = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        tx = 4'(x);
        ty = 4'(y);
        #1;
        if (occ !== expb[y][x]) bad++;
      end
  endtask

  task automatic run_frame(output int lat);
    @(negedge clk); screen_end = 1'b1;
    @(negedge clk); screen_end = 1'b0;
    lat = -1;
    for (int c = 1; c <= 300 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (fr) lat = c;
    end
  endtask

  task automatic test_reset;
    int bad;
    clear_all();
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (fr !== 1'b0) begin n_bad++; $display("FAIL reset_frame_ready: got %b want 0", fr); end
    n_cmp++; if ({sbcd, hbcd} !== 24'h0) begin n_bad++; $display("FAIL reset_bcd: got %h want 0", {sbcd, hbcd}); end
    n_cmp++; if ({oob, drop} !== 9'h0) begin n_bad++; $display("FAIL reset_oob_drop: got %h want 0", {oob, drop}); end
    reset = 1'b0;
    count_bad(bad);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL reset_bitmap: got %0d bad tiles want 0", bad); end
  endtask

  task automatic test_basic;
    int lat, bad;
    clear_all();
    set_slot(0, 3, 4); set_slot(1, 4, 4); set_slot(2, 5, 4);
    expb[4][3] = 1'b1; expb[4][4] = 1'b1; expb[4][5] = 1'b1;
    score = 7; high = 42;
    run_frame(lat);
    n_cmp++; if (lat !== 47) begin n_bad++; $display("FAIL basic_latency: got %0d want 47", lat); end
    n_cmp++; if (sbcd !== 12'h007) begin n_bad++; $display("FAIL basic_score: got %h want 007", sbcd); end
    n_cmp++; if (hbcd !== 12'h042) begin n_bad++; $display("FAIL basic_high: got %h want 042", hbcd); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (fr !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width: got %b want 0", fr); end
    count_bad(bad);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL basic_bitmap: got %0d bad tiles want 0", bad); end
  endtask

  task automatic fill_full;
    clear_all();
    for (int i = 0; i < MS; i++) begin
      set_slot(i, i % 12, (i / 12) % 10);
      expb[(i / 12) % 10][i % 12] = 1'b1;
    end
  endtask

  task automatic test_full;
    int lat, bad;
    fill_full();
    score = 999; high = 0;
    run_frame(lat);
    n_cmp++; if (lat !== 143) begin n_bad++; $display("FAIL full_latency: got %0d want 143", lat); end
    n_cmp++; if (oob !== 1'b0) begin n_bad++; $display("FAIL full_oob: got %b want 0", oob); end
    n_cmp++; if ({sbcd, hbcd} !== 24'h999000) begin n_bad++; $display("FAIL full_bcd: got %h want 999000", {sbcd, hbcd}); end
    count_bad(bad);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL full_bitmap: got %0d bad tiles want 0", bad); end
  endtask

  task automatic test_oob;
    int lat, bad;
    clear_all();
    set_slot(0, 12, 0); set_slot(1, 0, 10); set_slot(2, 2, 2);
    expb[2][2] = 1'b1;
    run_frame(lat);
    n_cmp++; if (lat !== 47) begin n_bad++; $display("FAIL oob_latency: got %0d want 47", lat); end
    n_cmp++; if (oob !== 1'b1) begin n_bad++; $display("FAIL oob_flag: got %b want 1", oob); end
    count_bad(bad);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL oob_bitmap: got %0d bad tiles want 0", bad); end
    set_slot(0, 2, 2); set_slot(1, 32'hFFFF_FFFF, 0);
    run_frame(lat);
    n_cmp++; if (lat !== 45) begin n_bad++; $display("FAIL clean_latency: got %0d want 45", lat); end
    n_cmp++; if (oob !== 1'b0) begin n_bad++; $display("FAIL clean_oob: got %b want 0", oob); end
    count_bad(bad);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL clean_bitmap: got %0d bad tiles want 0", bad); end
  endtask

  task automatic test_saturation;
    int lat;
    score = 1000; high = 32'hFFFF_FFFF;
    run_frame(lat);
    n_cmp++; if (sbcd !== 12'h999) begin n_bad++; $display("FAIL sat_score: got %h want 999", sbcd); end
    n_cmp++; if (hbcd !== 12'h999) begin n_bad++; $display("FAIL sat_high: got %h want 999", hbcd); end
    score = 580; high = 309;
    run_frame(lat);
    n_cmp++; if ({sbcd, hbcd} !== 24'h580309) begin n_bad++; $display("FAIL bcd_mixed: got %h want 580309", {sbcd, hbcd}); end
  endtask

  task automatic test_back_to_back;
    int lat, pulses;
    fill_full();
    score = 123; high = 456;
    tx = 0; ty = 5;
    @(negedge clk); screen_end = 1'b1;
    @(negedge clk); screen_end = 1'b0;
    lat = -1; pulses = 0;
    for (int c = 1; c <= 200; c++) begin
      screen_end = (c == 20 || c == 60);
      @(posedge clk); #1;
      if (fr) begin pulses++; lat = c; end
      if (c == 20) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drop_busy: got %b want 1", busy); end
      end
      if (c == 100) begin
        n_cmp++; if (occ !== 1'b0) begin n_bad++; $display("FAIL drop_front_stable: got %b want 0", occ); end
        n_cmp++; if (sbcd !== 12'h580) begin n_bad++; $display("FAIL drop_bcd_stable: got %h want 580", sbcd); end
      end
      @(negedge clk);
    end
    screen_end = 1'b0;
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL drop_pulses: got %0d want 1", pulses); end
    n_cmp++; if (lat !== 143) begin n_bad++; $display("FAIL drop_latency: got %0d want 143", lat); end
    #1;
    n_cmp++; if (occ !== 1'b1) begin n_bad++; $display("FAIL drop_new_frame: got %b want 1", occ); end
    n_cmp++; if ({sbcd, hbcd} !== 24'h123456) begin n_bad++; $display("FAIL drop_bcd: got %h want 123456", {sbcd, hbcd}); end
`ifdef FRAME_STATS_EN
    exp_drop = 8'd2;
`else
    exp_drop = 8'd0;
`endif
    n_cmp++; if (drop !== exp_drop) begin n_bad++; $display("FAIL drop_count: got %0d want %0d", drop, exp_drop); end
  endtask

  task automatic test_reset_mid;
    int pulses, bad;
    fill_full();
    @(negedge clk); screen_end = 1'b1;
    @(negedge clk); screen_end = 1'b0;
    repeat (48) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (fr) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL mid_reset_pulses: got %0d want 0", pulses); end
    n_cmp++; if ({sbcd, hbcd} !== 24'h0) begin n_bad++; $display("FAIL mid_reset_bcd: got %h want 0", {sbcd, hbcd}); end
    n_cmp++; if ({busy, oob, drop} !== 10'h0) begin n_bad++; $display("FAIL mid_reset_flags: got %h want 0", {busy, oob, drop}); end
    clear_all();
    count_bad(bad);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL mid_reset_bitmap: got %0d bad tiles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_oob();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
